// File: rtl/sram_arb_pkg.sv
// Shared encodings for the sram-like arbiter: transfer sizes, FSM states,
// and the ID width helper used to size channel IDs and the outstanding FIFO.
package sram_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Bits needed to name one of n channels; never less than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_arb_id_fifo.sv
// Outstanding-request ID FIFO: remembers which channel owns each accepted
// request so responses can be routed back in order.
module sram_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [ID_W-1:0]        push_id,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [ID_W-1:0]        head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [ID_W-1:0] mem [DEPTH];
  logic            do_push;
  logic            do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_id;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel round-robin arbiter onto one sram-like port with in-order response
// routing. Define SRAM_ARB_PROTO_CHECK_EN to build the sticky proto_err detector.
module sram_like_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4,
  localparam int CH_W   = id_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_wr,
  input  logic [2*NUM_CH-1:0]          ch_size,
  input  logic [ADDR_W*NUM_CH-1:0]     ch_addr,
  input  logic [DATA_W*NUM_CH-1:0]     ch_wdata,
  input  logic [(DATA_W/8)*NUM_CH-1:0] ch_wstrb,
  output logic [NUM_CH-1:0]            ch_addr_ok,
  output logic [NUM_CH-1:0]            ch_data_ok,
  output logic [DATA_W-1:0]            ch_rdata,
  output logic                         m_req,
  output logic                         m_wr,
  output logic [1:0]                   m_size,
  output logic [ADDR_W-1:0]            m_addr,
  output logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W/8-1:0]          m_wstrb,
  input  logic                         m_addr_ok,
  input  logic                         m_data_ok,
  input  logic [DATA_W-1:0]            m_rdata,
  output logic                         proto_err,
  output arb_state_t                   dbg_state,
  output logic [CH_W-1:0]              dbg_rr_ptr,
  output logic [$clog2(MAX_OUT):0]     dbg_out_cnt
);

  // Handshake: a channel holds ch_req and its fields until ch_addr_ok; the
  // downstream accepts when m_req & m_addr_ok, and answers later with m_data_ok.

  arb_state_t      state;
  logic [CH_W-1:0] lock_ch;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] winner;
  logic [CH_W-1:0] sel_ch;
  logic [CH_W-1:0] next_ptr;
  logic [CH_W-1:0] head;
  logic [NUM_CH-1:0] elig;
  logic            any_elig;
  logic            accept;
  logic            pop;
  logic            full;
  logic            empty;

  assign elig = ch_req & {NUM_CH{~full}};

  always_comb begin : rr_pick
    logic [CH_W:0] sum;
    sum      = '0;
    winner   = '0;
    any_elig = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      if (!any_elig && elig[sum[CH_W-1:0]]) begin
        any_elig = 1'b1;
        winner   = sum[CH_W-1:0];
      end
    end
  end

  // A locked channel keeps the port even if others become eligible.
  assign sel_ch   = (state == ST_LOCKED) ? lock_ch : winner;
  assign m_req    = resetn & ((state == ST_LOCKED) | any_elig);
  assign accept   = m_req & m_addr_ok;
  assign pop      = resetn & m_data_ok & ~empty;
  assign next_ptr = (sel_ch == CH_W'(NUM_CH - 1)) ? '0 : sel_ch + 1'b1;
  assign ch_rdata = m_rdata;

  always_comb begin
    m_wr    = ch_wr[0];
    m_size  = ch_size[1:0];
    m_addr  = ch_addr[ADDR_W-1:0];
    m_wdata = ch_wdata[DATA_W-1:0];
    m_wstrb = ch_wstrb[DATA_W/8-1:0];
    for (int i = 1; i < NUM_CH; i++) begin
      if (sel_ch == CH_W'(i)) begin
        m_wr    = ch_wr[i];
        m_size  = ch_size[2*i +: 2];
        m_addr  = ch_addr[ADDR_W*i +: ADDR_W];
        m_wdata = ch_wdata[DATA_W*i +: DATA_W];
        m_wstrb = ch_wstrb[(DATA_W/8)*i +: DATA_W/8];
      end
    end
  end

  always_comb begin
    ch_addr_ok = '0;
    ch_data_ok = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_addr_ok[i] = accept && (sel_ch == CH_W'(i));
      ch_data_ok[i] = pop && (head == CH_W'(i));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      lock_ch <= '0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_elig) begin
            if (m_addr_ok) begin
              rr_ptr <= next_ptr;
            end else begin
              lock_ch <= winner;
              state   <= ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (m_addr_ok) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SRAM_ARB_PROTO_CHECK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      proto_err <= 1'b0;
    end else if (((state == ST_LOCKED) && !ch_req[lock_ch]) || (m_data_ok && empty)) begin
      proto_err <= 1'b1;
    end
  end
`else
  assign proto_err = 1'b0;
`endif

  sram_arb_id_fifo #(
    .DEPTH (MAX_OUT),
    .ID_W  (CH_W)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .push_id (sel_ch),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head),
    .count   (dbg_out_cnt)
  );

  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus random
// traffic against a transaction-level model of grants and response order.
module tb_sram_like_arbiter;
  import sram_arb_pkg::*;

  localparam int NUM_CH  = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 4;
`ifdef SRAM_ARB_PROTO_CHECK_EN
  localparam bit PROTO_EN = 1'b1;
`else
  localparam bit PROTO_EN = 1'b0;
`endif

  logic                         clk;
  logic                         resetn;
  logic [NUM_CH-1:0]            ch_req;
  logic [NUM_CH-1:0]            ch_wr;
  logic [2*NUM_CH-1:0]          ch_size;
  logic [ADDR_W*NUM_CH-1:0]     ch_addr;
  logic [DATA_W*NUM_CH-1:0]     ch_wdata;
  logic [(DATA_W/8)*NUM_CH-1:0] ch_wstrb;
  logic [NUM_CH-1:0]            ch_addr_ok;
  logic [NUM_CH-1:0]            ch_data_ok;
  logic [DATA_W-1:0]            ch_rdata;
  logic                         m_req;
  logic                         m_wr;
  logic [1:0]                   m_size;
  logic [ADDR_W-1:0]            m_addr;
  logic [DATA_W-1:0]            m_wdata;
  logic [DATA_W/8-1:0]          m_wstrb;
  logic                         m_addr_ok;
  logic                         m_data_ok;
  logic [DATA_W-1:0]            m_rdata;
  logic                         proto_err;
  arb_state_t                   dbg_state;
  logic [0:0]                   dbg_rr_ptr;
  logic [2:0]                   dbg_out_cnt;

  sram_like_arbiter #(
    .NUM_CH (NUM_CH), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .MAX_OUT (MAX_OUT)
  ) dut (
    .clk (clk), .resetn (resetn),
    .ch_req (ch_req), .ch_wr (ch_wr), .ch_size (ch_size), .ch_addr (ch_addr),
    .ch_wdata (ch_wdata), .ch_wstrb (ch_wstrb),
    .ch_addr_ok (ch_addr_ok), .ch_data_ok (ch_data_ok), .ch_rdata (ch_rdata),
    .m_req (m_req), .m_wr (m_wr), .m_size (m_size), .m_addr (m_addr),
    .m_wdata (m_wdata), .m_wstrb (m_wstrb),
    .m_addr_ok (m_addr_ok), .m_data_ok (m_data_ok), .m_rdata (m_rdata),
    .proto_err (proto_err), .dbg_state (dbg_state), .dbg_rr_ptr (dbg_rr_ptr),
    .dbg_out_cnt (dbg_out_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  int unsigned n_vec;
  int unsigned n_err;

  logic [7:0]        exp_q[$];    // channel IDs in acceptance order
  int                exp_rr;      // channel to search from next
  int                pend;        // channel offered but not yet accepted, -1 if none
  bit                exp_err;
  bit                exp_mreq;
  int                exp_gnt;
  logic [NUM_CH-1:0] exp_addr_ok;
  logic [NUM_CH-1:0] exp_data_ok;

  task automatic model_reset();
    exp_q.delete();
    exp_rr  = 0;
    pend    = -1;
    exp_err = 1'b0;
  endtask

  task automatic model_eval();
    int idx;
    bit is_full;
    is_full  = (exp_q.size() == MAX_OUT);
    exp_mreq = 1'b0;
    exp_gnt  = 0;
    if (pend >= 0) begin
      exp_mreq = 1'b1;
      exp_gnt  = pend;
    end else if (!is_full) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (exp_rr + k) % NUM_CH;
        if (!exp_mreq && ch_req[idx]) begin
          exp_mreq = 1'b1;
          exp_gnt  = idx;
        end
      end
    end
    exp_addr_ok = '0;
    if (exp_mreq && m_addr_ok) exp_addr_ok[exp_gnt] = 1'b1;
    exp_data_ok = '0;
    if (m_data_ok && exp_q.size() > 0) exp_data_ok[exp_q[0]] = 1'b1;
  endtask

  task automatic model_commit();
    if (PROTO_EN && ((pend >= 0 && !ch_req[pend]) || (m_data_ok && exp_q.size() == 0)))
      exp_err = 1'b1;
    if (m_data_ok && exp_q.size() > 0) void'(exp_q.pop_front());
    if (exp_addr_ok != '0) begin
      exp_q.push_back(8'(exp_gnt));
      exp_rr = (exp_gnt + 1) % NUM_CH;
      pend   = -1;
    end else if (exp_mreq) begin
      pend = exp_gnt;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wdata = '0; ch_wstrb = '0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
  endtask

  task automatic raise(input int ch, input bit wr, input logic [ADDR_W-1:0] addr);
    ch_req[ch]                         = 1'b1;
    ch_wr[ch]                          = wr;
    ch_size[2*ch +: 2]                 = 2'($urandom_range(0, 2));
    ch_addr[ch*ADDR_W +: ADDR_W]       = addr;
    ch_wdata[ch*DATA_W +: DATA_W]      = $urandom;
    ch_wstrb[ch*(DATA_W/8) +: DATA_W/8] = 4'($urandom_range(0, 15));
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  // Masters drop ch_req once accepted; downstream strobes are single-cycle.
  task automatic tick();
    model_commit();
    @(posedge clk);
    @(negedge clk);
    ch_req    = ch_req & ~exp_addr_ok;
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 3 * MAX_OUT && exp_q.size() > 0; c++) begin
      m_data_ok = 1'b1;
      m_rdata   = $urandom;
      settle();
      n_vec++;
      if (ch_data_ok !== exp_data_ok) begin
        n_err++;
        $display("FAIL drain data_ok: got %b want %b", ch_data_ok, exp_data_ok);
      end
      n_vec++;
      if (ch_rdata !== m_rdata) begin
        n_err++;
        $display("FAIL drain rdata: got %h want %h", ch_rdata, m_rdata);
      end
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    ch_req = '1; m_addr_ok = 1'b1; m_data_ok = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (m_req !== 1'b0) begin n_err++; $display("FAIL reset m_req: got %b want 0", m_req); end
    n_vec++;
    if (ch_addr_ok !== '0) begin n_err++; $display("FAIL reset addr_ok: got %b want 0", ch_addr_ok); end
    n_vec++;
    if (ch_data_ok !== '0) begin n_err++; $display("FAIL reset data_ok: got %b want 0", ch_data_ok); end
    n_vec++;
    if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset proto_err: got %b want 0", proto_err); end
    n_vec++;
    if (dbg_state !== ST_IDLE || dbg_rr_ptr !== 1'b0 || dbg_out_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL reset state: got st=%0d rr=%0d cnt=%0d want 0/0/0", dbg_state, dbg_rr_ptr, dbg_out_cnt);
    end
    clear_inputs();
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    raise(1, 1'b0, 32'h1FC0_0000);
    m_addr_ok = 1'b1;
    settle();
    n_vec++;
    if (m_req !== 1'b1 || m_addr !== 32'h1FC0_0000 || m_wr !== 1'b0) begin
      n_err++;
      $display("FAIL single m_fields: got req=%b addr=%h wr=%b want 1/1fc00000/0", m_req, m_addr, m_wr);
    end
    n_vec++;
    if (ch_addr_ok !== 2'b10) begin n_err++; $display("FAIL single addr_ok: got %b want 10", ch_addr_ok); end
    tick();
    for (int c = 0; c < 2; c++) begin
      settle();
      n_vec++;
      if (ch_addr_ok !== '0 || ch_data_ok !== '0) begin
        n_err++;
        $display("FAIL single idle: got addr_ok=%b data_ok=%b want 00/00", ch_addr_ok, ch_data_ok);
      end
      tick();
    end
    m_data_ok = 1'b1;
    m_rdata   = 32'hDEAD_BEEF;
    settle();
    n_vec++;
    if (ch_data_ok !== 2'b10 || ch_rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL single response: got data_ok=%b rdata=%h want 10/deadbeef", ch_data_ok, ch_rdata);
    end
    tick();
    n_vec++;
    if (dbg_rr_ptr !== 1'b0 || dbg_out_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL single after: got rr=%0d cnt=%0d want 0/0", dbg_rr_ptr, dbg_out_cnt);
    end
  endtask

  task automatic test_alternate();
    logic [NUM_CH-1:0] want;
    logic [ADDR_W-1:0] ea;
    for (int c = 0; c < 8; c++) begin
      for (int ch = 0; ch < NUM_CH; ch++)
        if (!ch_req[ch]) raise(ch, 1'($urandom_range(0, 1)), $urandom);
      m_addr_ok = 1'b1;
      m_data_ok = (exp_q.size() > 0);
      m_rdata   = $urandom;
      settle();
      want = (c % 2 == 0) ? 2'b01 : 2'b10;
      ea   = ch_addr[exp_gnt*ADDR_W +: ADDR_W];
      n_vec++;
      if (ch_addr_ok !== want) begin
        n_err++;
        $display("FAIL alternate grant %0d: got %b want %b", c, ch_addr_ok, want);
      end
      n_vec++;
      if (m_addr !== ea) begin n_err++; $display("FAIL alternate m_addr %0d: got %h want %h", c, m_addr, ea); end
      n_vec++;
      if (ch_data_ok !== exp_data_ok) begin
        n_err++;
        $display("FAIL alternate data_ok %0d: got %b want %b", c, ch_data_ok, exp_data_ok);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_lock_hold();
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    a0 = $urandom;
    a1 = ~a0;
    raise(0, 1'b1, a0);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) raise(1, 1'b0, a1);
      settle();
      n_vec++;
      if (m_req !== 1'b1 || m_addr !== a0 || m_wr !== 1'b1 || ch_addr_ok !== '0) begin
        n_err++;
        $display("FAIL lock hold %0d: got req=%b addr=%h wr=%b ok=%b want 1/%h/1/00",
                 c, m_req, m_addr, m_wr, ch_addr_ok, a0);
      end
      tick();
      n_vec++;
      if (dbg_state !== ST_LOCKED) begin n_err++; $display("FAIL lock state %0d: got %0d want 1", c, dbg_state); end
    end
    m_addr_ok = 1'b1;
    settle();
    n_vec++;
    if (ch_addr_ok !== 2'b01 || m_addr !== a0) begin
      n_err++;
      $display("FAIL lock accept: got ok=%b addr=%h want 01/%h", ch_addr_ok, m_addr, a0);
    end
    tick();
    m_addr_ok = 1'b1;
    settle();
    n_vec++;
    if (ch_addr_ok !== 2'b10 || m_addr !== a1 || m_wr !== 1'b0) begin
      n_err++;
      $display("FAIL lock next: got ok=%b addr=%h wr=%b want 10/%h/0", ch_addr_ok, m_addr, m_wr, a1);
    end
    tick();
    m_data_ok = 1'b1;
    settle();
    n_vec++;
    if (ch_data_ok !== 2'b01) begin n_err++; $display("FAIL lock first resp: got %b want 01", ch_data_ok); end
    tick();
    drain();
  endtask

  task automatic test_full();
    for (int c = 0; c < MAX_OUT; c++) begin
      raise(0, 1'b0, $urandom);
      m_addr_ok = 1'b1;
      settle();
      n_vec++;
      if (ch_addr_ok !== 2'b01) begin n_err++; $display("FAIL full fill %0d: got %b want 01", c, ch_addr_ok); end
      tick();
    end
    n_vec++;
    if (dbg_out_cnt !== 3'(MAX_OUT)) begin n_err++; $display("FAIL full count: got %0d want %0d", dbg_out_cnt, MAX_OUT); end
    raise(0, 1'b0, $urandom);
    m_addr_ok = 1'b1;
    settle();
    n_vec++;
    if (m_req !== 1'b0 || ch_addr_ok !== '0) begin
      n_err++;
      $display("FAIL full blocked: got req=%b ok=%b want 0/00", m_req, ch_addr_ok);
    end
    tick();
    m_data_ok = 1'b1;
    settle();
    n_vec++;
    if (m_req !== 1'b0 || ch_data_ok !== 2'b01) begin
      n_err++;
      $display("FAIL full pop cycle: got req=%b data_ok=%b want 0/01", m_req, ch_data_ok);
    end
    tick();
    m_addr_ok = 1'b1;
    settle();
    n_vec++;
    if (m_req !== 1'b1 || ch_addr_ok !== 2'b01) begin
      n_err++;
      $display("FAIL full resume: got req=%b ok=%b want 1/01", m_req, ch_addr_ok);
    end
    tick();
    drain();
  endtask

  task automatic test_push_pop();
    raise(0, 1'b0, $urandom);
    raise(1, 1'b1, $urandom);
    for (int c = 0; c < 2; c++) begin
      m_addr_ok = 1'b1;
      settle();
      tick();
    end
    n_vec++;
    if (dbg_out_cnt !== 3'd2) begin n_err++; $display("FAIL pushpop pre count: got %0d want 2", dbg_out_cnt); end
    raise(0, 1'b0, $urandom);
    m_addr_ok = 1'b1;
    m_data_ok = 1'b1;
    m_rdata   = $urandom;
    settle();
    n_vec++;
    if (ch_addr_ok !== exp_addr_ok || ch_data_ok !== exp_data_ok) begin
      n_err++;
      $display("FAIL pushpop strobes: got %b/%b want %b/%b", ch_addr_ok, ch_data_ok, exp_addr_ok, exp_data_ok);
    end
    tick();
    n_vec++;
    if (dbg_out_cnt !== 3'd2) begin n_err++; $display("FAIL pushpop count: got %0d want 2", dbg_out_cnt); end
    drain();
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    for (int c = 0; c < 400; c++) begin
      for (int ch = 0; ch < NUM_CH; ch++)
        if (!ch_req[ch] && $urandom_range(0, 1) == 1) raise(ch, 1'($urandom_range(0, 1)), $urandom);
      m_addr_ok = ($urandom_range(0, 2) != 0);
      m_data_ok = (exp_q.size() > 0) && ($urandom_range(0, 2) == 0);
      m_rdata   = $urandom;
      settle();
      n_vec++;
      if (m_req !== exp_mreq) begin n_err++; $display("FAIL random m_req %0d: got %b want %b", c, m_req, exp_mreq); end
      if (exp_mreq) begin
        ea = ch_addr[exp_gnt*ADDR_W +: ADDR_W];
        ed = ch_wdata[exp_gnt*DATA_W +: DATA_W];
        n_vec++;
        if (m_addr !== ea || m_wdata !== ed || m_wr !== ch_wr[exp_gnt] ||
            m_size !== ch_size[2*exp_gnt +: 2] || m_wstrb !== ch_wstrb[exp_gnt*4 +: 4]) begin
          n_err++;
          $display("FAIL random fields %0d: got addr=%h wdata=%h want addr=%h wdata=%h (ch %0d)",
                   c, m_addr, m_wdata, ea, ed, exp_gnt);
        end
      end
      n_vec++;
      if (ch_addr_ok !== exp_addr_ok) begin
        n_err++;
        $display("FAIL random addr_ok %0d: got %b want %b", c, ch_addr_ok, exp_addr_ok);
      end
      n_vec++;
      if (ch_data_ok !== exp_data_ok) begin
        n_err++;
        $display("FAIL random data_ok %0d: got %b want %b", c, ch_data_ok, exp_data_ok);
      end
      n_vec++;
      if (proto_err !== exp_err) begin n_err++; $display("FAIL random proto_err %0d: got %b want %b", c, proto_err, exp_err); end
      n_vec++;
      if (dbg_out_cnt !== 3'(exp_q.size())) begin
        n_err++;
        $display("FAIL random count %0d: got %0d want %0d", c, dbg_out_cnt, exp_q.size());
      end
      tick();
    end
    for (int c = 0; c < 10 && ch_req != '0; c++) begin
      m_addr_ok = 1'b1;
      m_data_ok = (exp_q.size() > 0);
      settle();
      n_vec++;
      if (ch_addr_ok !== exp_addr_ok || ch_data_ok !== exp_data_ok) begin
        n_err++;
        $display("FAIL random flush %0d: got %b/%b want %b/%b", c, ch_addr_ok, ch_data_ok, exp_addr_ok, exp_data_ok);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_proto_empty();
    m_data_ok = 1'b1;
    m_rdata   = $urandom;
    settle();
    n_vec++;
    if (ch_data_ok !== '0 || proto_err !== 1'b0) begin
      n_err++;
      $display("FAIL proto empty strobe: got data_ok=%b err=%b want 00/0", ch_data_ok, proto_err);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      settle();
      n_vec++;
      if (proto_err !== PROTO_EN) begin
        n_err++;
        $display("FAIL proto empty sticky %0d: got %b want %b", c, proto_err, PROTO_EN);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    raise(0, 1'b0, $urandom);
    raise(1, 1'b1, $urandom);
    m_addr_ok = 1'b1;
    settle();
    tick();
    settle();
    tick();
    resetn    = 1'b0;
    ch_req    = '1;
    m_addr_ok = 1'b1;
    m_data_ok = 1'b1;
    #1;
    n_vec++;
    if (m_req !== 1'b0 || ch_addr_ok !== '0 || ch_data_ok !== '0 || proto_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset mid outputs: got req=%b aok=%b dok=%b err=%b want 0", m_req, ch_addr_ok, ch_data_ok, proto_err);
    end
    n_vec++;
    if (dbg_out_cnt !== 3'd0 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset mid state: got cnt=%0d st=%0d want 0/0", dbg_out_cnt, dbg_state);
    end
    clear_inputs();
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    settle();
    n_vec++;
    if (dbg_out_cnt !== 3'd0 || proto_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset mid after: got cnt=%0d err=%b want 0/0", dbg_out_cnt, proto_err);
    end
    tick();
  endtask

  task automatic test_proto_lock_drop();
    logic [ADDR_W-1:0] a0;
    a0 = $urandom;
    raise(0, 1'b0, a0);
    settle();
    tick();
    ch_req[0] = 1'b0;
    settle();
    n_vec++;
    if (m_req !== 1'b1 || m_addr !== a0) begin
      n_err++;
      $display("FAIL drop hold: got req=%b addr=%h want 1/%h", m_req, m_addr, a0);
    end
    tick();
    n_vec++;
    if (proto_err !== PROTO_EN) begin n_err++; $display("FAIL drop proto_err: got %b want %b", proto_err, PROTO_EN); end
    m_addr_ok = 1'b1;
    settle();
    n_vec++;
    if (ch_addr_ok !== 2'b01) begin n_err++; $display("FAIL drop accept: got %b want 01", ch_addr_ok); end
    tick();
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    test_reset();
    test_single_read();
    test_alternate();
    test_lock_hold();
    test_full();
    test_push_pop();
    test_random();
    test_proto_empty();
    test_reset_mid();
    test_proto_lock_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Parametrised N-channel arbiter merging sram-like master ports (fetch, data, future uncached/prefetch) onto one downstream sram-like port feeding the AXI bridge/cache.
- Round-robin address-phase grant with request locking; in-order response routing through an outstanding-ID FIFO.
- Successor to the fixed two-port inst/data hookup at the core top: generalises channel count, widths and outstanding depth.

Parameters:
- NUM_CH, 2, number of upstream channels (≥2); channel 0 is conventionally instruction fetch.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- MAX_OUT, 4, maximum outstanding accepted-but-unanswered requests (power of 2, ≥2).

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- ch_req  in  NUM_CH  per-channel request valid; held with its fields until ch_addr_ok.
- ch_wr  in  NUM_CH  1 = write.
- ch_size  in  2*NUM_CH  0 = byte, 1 = half, 2 = word.
- ch_addr  in  ADDR_W*NUM_CH  flattened addresses.
- ch_wdata  in  DATA_W*NUM_CH  write data.
- ch_wstrb  in  (DATA_W/8)*NUM_CH  byte strobes.
- ch_addr_ok  out  NUM_CH  address-phase accept, one-hot.
- ch_data_ok  out  NUM_CH  response strobe, one-hot.
- ch_rdata  out  DATA_W  shared read data; valid only with a ch_data_ok bit.
- m_req / m_wr / m_size / m_addr / m_wdata / m_wstrb  out  1/1/2/ADDR_W/DATA_W/DATA_W/8  downstream request.
- m_addr_ok  in  1  downstream accept.
- m_data_ok  in  1  downstream response.
- m_rdata  in  DATA_W  downstream read data.
- proto_err  out  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- FSM states IDLE and LOCKED; reset state IDLE, rr_ptr = 0, FIFO empty, proto_err = 0. m_req and all *_ok outputs are 0 during reset.
- Eligibility: a channel is eligible when its ch_req = 1 and the FIFO is not full. Full blocks grants even if a pop occurs in the same cycle.
- IDLE: the winner is the first eligible channel searching from rr_ptr upward, wrapping at NUM_CH-1 to 0. m_req = 1 and m_* carry the winner's fields combinationally.
  - If m_addr_ok = 1 in the same cycle: ch_addr_ok[winner] = 1, push winner ID, rr_ptr = winner+1 mod NUM_CH, stay IDLE.
  - Otherwise: lock_ch <= winner, go to LOCKED.
- LOCKED: m_req = 1 with lock_ch's fields; other channels are ignored.
  - On m_addr_ok: ch_addr_ok[lock_ch] = 1, push, rr_ptr = lock_ch+1, return to IDLE.
  - If lock_ch drops ch_req (protocol violation): hold m_req anyway; set proto_err when enabled.
- Response path: on m_data_ok with FIFO non-empty, ch_data_ok[head] = 1, ch_rdata = m_rdata (zero-latency pass-through), pop.
  - m_data_ok with FIFO empty: ignored; proto_err set when enabled.
- Simultaneous push and pop in one cycle: count unchanged, pointers both advance.
- FIFO pointers are log2(MAX_OUT)+1 bits; full/empty are decided by MSB compare.
- A response is never returned in the same cycle as its own address accept (the downstream guarantees this).
- Reset mid-transaction discards all outstanding IDs; the downstream must be reset together with this block.

Optional Feature:
- Macro SRAM_ARB_PROTO_CHECK_EN.
- Defined: proto_err latches 1 on data_ok with an empty FIFO, or on a locked channel dropping ch_req. It is cleared only by reset.
- Undefined: proto_err is tied to 0 and the detection logic is absent; the rest of the behaviour is identical.

Decomposition:
- Package sram_arb_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encoding (ST_IDLE/ST_LOCKED), and a clog2-based ID-width constant function.
- Sub-module sram_arb_id_fifo: MAX_OUT-deep, ID-wide synchronous FIFO with push/pop/full/empty/head. The top contains the rr picker, FSM and muxes.

Test Plan:
- Single channel 1 read of 0x1FC0_0000; m_addr_ok in the same cycle, m_data_ok 3 cycles later with 0xDEAD_BEEF → ch_addr_ok[1] pulses once, ch_data_ok[1] pulses with ch_rdata = 0xDEAD_BEEF, rr_ptr = 0.
- Both channels request continuously, m_addr_ok always 1 → grants alternate 0,1,0,1; responses return in push order.
- m_addr_ok held low 5 cycles while ch0 is locked; ch1 raises req at cycle 2 → m_addr/m_wr stay on ch0 until accept; ch1 is granted next.
- MAX_OUT = 4: four accepts with no data_ok → fifth request gets no grant and m_req = 0; one data_ok → grant resumes the cycle after.
- Same-cycle push and pop at count 2 → count stays 2; the IDs of the following responses are correct.
- With the macro defined: m_data_ok with an empty FIFO → proto_err = 1 and stays set; assert resetn = 0 mid-traffic → all outputs 0, FIFO empty.
